// File: rtl/full_adder_top.sv
// Single-bit full adder computed structurally, as dataflow and behaviourally,
// with a registered behavioural result and a sticky cross-check flag.

module fa_half_adder (
    input  logic      a,
    input  logic      b,
    output wire logic s,
    output wire logic c
);

    xor g_s (s, a, b);
    and g_c (c, a, b);

endmodule

module full_adder_top (
    input  logic      clk,
    input  logic      rst,
    input  logic      x,
    input  logic      y,
    input  logic      c_in,
    output wire logic sum_st,
    output wire logic sum_df,
    output logic      sum_bh,
    output wire logic c_out_st,
    output wire logic c_out_df,
    output logic      c_out_bh,
    output logic      sum_q,
    output logic      c_out_q,
    output logic      mismatch
);

    wire logic s1;
    wire logic c1;
    wire logic c2;

    logic [1:0] bh_res;
    logic       disagree;
    logic       mismatch_q;
    logic       mismatch_d;

    fa_half_adder u_ha1 (
        .a (x),
        .b (y),
        .s (s1),
        .c (c1)
    );

    fa_half_adder u_ha2 (
        .a (s1),
        .b (c_in),
        .s (sum_st),
        .c (c2)
    );

    or g_cout (c_out_st, c1, c2);

    assign sum_df   = x ^ y ^ c_in;
    assign c_out_df = (x & y) | (c_in & (x ^ y));

    always_comb begin
        bh_res   = {1'b0, x} + {1'b0, y} + {1'b0, c_in};
        sum_bh   = bh_res[0];
        c_out_bh = bh_res[1];
    end

    // Any pairwise disagreement between the three styles latches the flag.
    assign disagree = (sum_st != sum_df) | (sum_df != sum_bh)
                    | (c_out_st != c_out_df) | (c_out_df != c_out_bh);

    assign mismatch_d = mismatch_q | disagree;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= 1'b0;
            c_out_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            sum_q      <= sum_bh;
            c_out_q    <= c_out_bh;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_full_adder_top.sv
// Bench for full_adder_top: directed sweeps plus random vectors checked
// against an arithmetic reference model.

module tb_full_adder_top;

    logic clk;
    logic clk_run;
    logic rst;
    logic x;
    logic y;
    logic c_in;
    wire  sum_st;
    wire  sum_df;
    logic sum_bh;
    wire  c_out_st;
    wire  c_out_df;
    logic c_out_bh;
    logic sum_q;
    logic c_out_q;
    logic mismatch;

    int n_vec;
    int n_err;

    logic exp_sq;
    logic exp_cq;
    logic exp_mm;
    logic forced;

    full_adder_top dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .c_in     (c_in),
        .sum_st   (sum_st),
        .sum_df   (sum_df),
        .sum_bh   (sum_bh),
        .c_out_st (c_out_st),
        .c_out_df (c_out_df),
        .c_out_bh (c_out_bh),
        .sum_q    (sum_q),
        .c_out_q  (c_out_q),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_add(input logic [2:0] v);
        int total;
        total = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return total[1:0];
    endfunction

    task automatic check_comb(input string tag);
        logic [1:0] r;
        r = ref_add({x, y, c_in});
        chk({tag, " sum_st"}, sum_st, r[0]);
        chk({tag, " sum_df"}, sum_df, r[0]);
        chk({tag, " sum_bh"}, sum_bh, r[0]);
        chk({tag, " c_out_st"}, c_out_st, r[1]);
        chk({tag, " c_out_df"}, c_out_df, r[1]);
        chk({tag, " c_out_bh"}, c_out_bh, r[1]);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " sum_q"}, sum_q, exp_sq);
        chk({tag, " c_out_q"}, c_out_q, exp_cq);
        chk({tag, " mismatch"}, mismatch, exp_mm);
    endtask

    task automatic apply(input logic [2:0] v);
        @(negedge clk);
        {x, y, c_in} = v;
        #1;
    endtask

    // Advance one rising edge and update the expected register state.
    task automatic tick();
        logic [1:0] r;
        r = ref_add({x, y, c_in});
        @(posedge clk);
        if (rst) begin
            exp_sq = 1'b0;
            exp_cq = 1'b0;
            exp_mm = 1'b0;
        end else begin
            exp_sq = r[0];
            exp_cq = r[1];
            exp_mm = exp_mm | forced;
        end
        #1;
    endtask

    initial begin
        logic [2:0] v;
        logic [7:0] sweep_sum;
        logic [7:0] sweep_cry;
        n_vec     = 0;
        n_err     = 0;
        clk_run   = 1'b1;
        forced    = 1'b0;
        exp_mm    = 1'b0;
        sweep_sum = 8'b1001_0110;
        sweep_cry = 8'b1110_1000;
        rst       = 1'b1;
        {x, y, c_in} = 3'b000;
        tick();
        tick();
        check_regs("reset");

        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            apply(v);
            check_comb("sweep");
            chk("sweep table sum", sum_bh, sweep_sum[i]);
            chk("sweep table carry", c_out_df, sweep_cry[i]);
            tick();
            check_regs("sweep reg");
        end

        apply(3'b111);
        tick();
        check_regs("latency 111");
        apply(3'b000);
        chk("hold sum_q", sum_q, 1'b1);
        chk("hold c_out_q", c_out_q, 1'b1);
        tick();
        check_regs("latency 000");

        apply(3'b111);
        rst = 1'b1;
        tick();
        check_regs("rst 111");
        check_comb("rst comb");
        rst = 1'b0;
        tick();
        check_regs("post rst");

        apply(3'b000);
        force dut.sum_st = 1'b1;
        forced = 1'b1;
        tick();
        check_regs("forced");
        @(negedge clk);
        release dut.sum_st;
        forced = 1'b0;
        #1;
        check_comb("released");
        tick();
        check_regs("sticky");
        tick();
        check_regs("sticky2");
        rst = 1'b1;
        tick();
        check_regs("sticky clr");
        rst = 1'b0;

        for (int i = 0; i < 60; i++) begin
            v = 3'($urandom_range(0, 7));
            apply(v);
            rst = ($urandom_range(0, 9) == 0);
            check_comb("rand");
            tick();
            check_regs("rand reg");
        end
        rst = 1'b0;

        @(negedge clk);
        clk_run = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            {x, y, c_in} = 3'(i);
            #3;
            check_comb("noclk");
        end
        chk("noclk sum_q", sum_q, exp_sq);
        chk("noclk c_out_q", c_out_q, exp_cq);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
